clock_panel: RTL and testbench

- Front-panel input conditioner that drives the control inputs of the CPU clock generator: `mode`, `manual_toggle` and `halt`.
- Synchronises and debounces the raw mode switch, step button and resume button.
- Turns step presses into single-cycle `manual_toggle` pulses, with auto-repeat while the button is held.
- Keeps a halt latch: the CPU sets it, the resume button clears it.

---
 rtl/clock_panel_pkg.sv | 18 +
 rtl/input_debounce.sv | 47 ++++
 rtl/clock_panel.sv | 122 ++++++++++++
 tb/tb_clock_panel.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/clock_panel_pkg.sv
// Shared types and helpers for the front-panel clock control block.
package clock_panel_pkg;

    // Step-button auto-repeat states
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DELAY  = 2'd1,
        REPEAT = 2'd2
    } step_state_t;

    // Bits needed for a counter that must hold max(limit,1)
    function automatic int unsigned cnt_width(input int unsigned limit);
        int unsigned v;
        v = (limit < 32'd1) ? 32'd1 : limit;
        return $clog2(v + 32'd1);
    endfunction

endpackage

// File: rtl/input_debounce.sv
// Two-flop synchroniser followed by a consecutive-cycle debounce counter.
// 'rise' is a registered one-cycle strobe on a debounced 0->1 transition.
module input_debounce
    import clock_panel_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 4
)
(
    input  logic sys_clk,
    input  logic rst,
    input  logic raw,
    output logic stable,
    output logic rise
);

    localparam int unsigned CW = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES);

    logic          sync1;
    logic          sync2;
    logic [CW-1:0] cnt;

    // Synchronise, then accept a new level only after it persists CNT_MAX+1 compares
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            sync1  <= 1'b0;
            sync2  <= 1'b0;
            stable <= 1'b0;
            rise   <= 1'b0;
            cnt    <= '0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            rise  <= 1'b0;
            if (sync2 == stable) begin
                cnt <= '0;
            end else if (cnt == CNT_MAX) begin
                stable <= sync2;
                rise   <= sync2;
                cnt    <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/clock_panel.sv
// Front-panel conditioner: debounced mode, step pulses with auto-repeat, halt latch.
module clock_panel
    import clock_panel_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned REPEAT_DELAY    = 10,
    parameter int unsigned REPEAT_PERIOD   = 5
)
(
    input  logic sys_clk,
    input  logic rst,
    input  logic sw_mode,
    input  logic btn_step,
    input  logic btn_resume,
    input  logic cpu_halt,
    output logic mode,
    output logic manual_toggle,
    output logic halt
);

    localparam int unsigned RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int unsigned RW      = cnt_width(RPT_MAX);
    localparam logic [RW-1:0] DELAY_LOAD  = RW'(REPEAT_DELAY);
    localparam logic [RW-1:0] PERIOD_LOAD = RW'(REPEAT_PERIOD);
    localparam logic [RW-1:0] CNT_ONE     = RW'(1);
    localparam logic          REPEAT_ON   = (REPEAT_PERIOD > 0);

    logic          mode_rise_unused;
    logic          step_lvl;
    logic          step_rise;
    logic          resume_lvl_unused;
    logic          resume_rise;
    step_state_t   state;
    logic [RW-1:0] rpt_cnt;

    input_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_mode (
        .sys_clk (sys_clk),
        .rst     (rst),
        .raw     (sw_mode),
        .stable  (mode),
        .rise    (mode_rise_unused)
    );

    input_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_step (
        .sys_clk (sys_clk),
        .rst     (rst),
        .raw     (btn_step),
        .stable  (step_lvl),
        .rise    (step_rise)
    );

    input_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_resume (
        .sys_clk (sys_clk),
        .rst     (rst),
        .raw     (btn_resume),
        .stable  (resume_lvl_unused),
        .rise    (resume_rise)
    );

    // Step FSM: first pulse on press, then delay, then periodic repeat; release wins over expiry
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            state         <= IDLE;
            rpt_cnt       <= '0;
            manual_toggle <= 1'b0;
        end else begin
            manual_toggle <= 1'b0;
            case (state)
                IDLE: begin
                    if (step_rise) begin
                        manual_toggle <= mode;
                        rpt_cnt       <= DELAY_LOAD;
                        state         <= DELAY;
                    end
                end
                DELAY: begin
                    if (!step_lvl) begin
                        rpt_cnt <= '0;
                        state   <= IDLE;
                    end else if (rpt_cnt <= CNT_ONE) begin
                        if (REPEAT_ON) begin
                            manual_toggle <= mode;
                            rpt_cnt       <= PERIOD_LOAD;
                            state         <= REPEAT;
                        end else begin
                            rpt_cnt <= '0;
                        end
                    end else begin
                        rpt_cnt <= rpt_cnt - CNT_ONE;
                    end
                end
                REPEAT: begin
                    if (!step_lvl) begin
                        rpt_cnt <= '0;
                        state   <= IDLE;
                    end else if (rpt_cnt <= CNT_ONE) begin
                        manual_toggle <= mode;
                        rpt_cnt       <= PERIOD_LOAD;
                    end else begin
                        rpt_cnt <= rpt_cnt - CNT_ONE;
                    end
                end
                default: begin
                    rpt_cnt <= '0;
                    state   <= IDLE;
                end
            endcase
        end
    end

    // Halt latch: CPU request sets (and dominates), debounced resume press clears
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            halt <= 1'b0;
        end else if (cpu_halt) begin
            halt <= 1'b1;
        end else if (resume_rise) begin
            halt <= 1'b0;
        end
    end

endmodule

// File: tb/tb_clock_panel.sv
// Self-checking bench for clock_panel: step-press vector table plus hand sequences.
module tb_clock_panel;

    localparam int DEB  = 4;
    localparam int RDLY = 10;
    localparam int RPER = 5;
    // Raw change driven in cycle k: first sampling edge is k+1, pulse follows DEB+3 edges later
    localparam int PULSE_LAT = 1 + DEB + 3;
    localparam int MODE_LAT  = 1 + DEB + 2;

    logic sys_clk    = 1'b0;
    logic rst        = 1'b1;
    logic sw_mode    = 1'b0;
    logic btn_step   = 1'b0;
    logic btn_resume = 1'b0;
    logic cpu_halt   = 1'b0;
    logic mode;
    logic manual_toggle;
    logic halt;

    int cyc         = 0;
    int n_checks    = 0;
    int n_fail      = 0;
    int pulses_seen = 0;
    int exp_t;
    int exp_q[$];

    typedef struct {
        logic sw;
        int   hold;
        int   exp_n;
    } step_vec_t;

    step_vec_t vecs[8];

    clock_panel #(
        .DEBOUNCE_CYCLES (DEB),
        .REPEAT_DELAY    (RDLY),
        .REPEAT_PERIOD   (RPER)
    ) dut (
        .sys_clk       (sys_clk),
        .rst           (rst),
        .sw_mode       (sw_mode),
        .btn_step      (btn_step),
        .btn_resume    (btn_resume),
        .cpu_halt      (cpu_halt),
        .mode          (mode),
        .manual_toggle (manual_toggle),
        .halt          (halt)
    );

    always #5 sys_clk = ~sys_clk;

    always @(posedge sys_clk) cyc <= cyc + 1;

    task automatic tick(input int n);
        repeat (n) @(negedge sys_clk);
    endtask

    task automatic check_bit(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Scoreboard: every observed pulse must match the oldest expected pulse cycle
    always @(negedge sys_clk) begin
        while (exp_q.size() > 0 && exp_q[0] < cyc) begin
            exp_t = exp_q.pop_front();
            n_checks++;
            n_fail++;
            $display("FAIL pulse_missing: no pulse at cycle %0d (now %0d)", exp_t, cyc);
        end
        if (manual_toggle === 1'b1) begin
            pulses_seen++;
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL pulse_unexpected: pulse at cycle %0d, none expected", cyc);
            end else begin
                exp_t = exp_q.pop_front();
                if (exp_t != cyc) begin
                    n_fail++;
                    $display("FAIL pulse_time: pulse at cycle %0d expected at %0d", cyc, exp_t);
                end
            end
        end
    end

    // Expected pulse cycles for a press driven in cycle k
    task automatic push_pulses(input int k, input int n);
        for (int p = 0; p < n; p++)
            exp_q.push_back(k + PULSE_LAT + ((p == 0) ? 0 : RDLY + (p - 1) * RPER));
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        int r;

        // {sw_mode, raw hold cycles, expected pulse count}
        vecs[0] = '{1'b1, 3,  0};   // glitch shorter than debounce
        vecs[1] = '{1'b1, 4,  0};   // one cycle short of acceptance
        vecs[2] = '{1'b1, 5,  1};   // shortest accepted press
        vecs[3] = '{1'b1, 8,  1};   // single press, no repeat
        vecs[4] = '{1'b1, 10, 1};   // release coincides with delay expiry
        vecs[5] = '{1'b1, 11, 2};   // one cycle longer: first repeat emitted
        vecs[6] = '{1'b0, 20, 0};   // continuous mode gates pulses
        vecs[7] = '{1'b1, 40, 7};   // long hold: delay then periodic repeat

        // Reset state
        tick(3);
        check_bit("reset_mode", mode, 1'b0);
        check_bit("reset_toggle", manual_toggle, 1'b0);
        check_bit("reset_halt", halt, 1'b0);
        rst = 1'b0;
        tick(5);

        // Mode latency
        k = cyc;
        sw_mode = 1'b1;
        tick(MODE_LAT - 1);
        check_bit("mode_before_lat", mode, 1'b0);
        tick(1);
        check_bit("mode_at_lat", mode, 1'b1);
        check_int("mode_lat_cycle", cyc - k, MODE_LAT);
        tick(5);

        // Step-press table
        for (int i = 0; i < 8; i++) begin
            sw_mode = vecs[i].sw;
            tick(12);
            check_bit($sformatf("vec%0d_mode", i), mode, vecs[i].sw);
            pulses_seen = 0;
            k = cyc;
            btn_step = 1'b1;
            push_pulses(k, vecs[i].exp_n);
            tick(vecs[i].hold);
            btn_step = 1'b0;
            tick(25);
            check_int($sformatf("vec%0d_pulse_count", i), pulses_seen, vecs[i].exp_n);
            check_int($sformatf("vec%0d_pending", i), exp_q.size(), 0);
        end
        sw_mode = 1'b1;
        tick(12);

        // Halt: one-cycle request sets and holds
        check_bit("halt_idle", halt, 1'b0);
        cpu_halt = 1'b1;
        tick(1);
        cpu_halt = 1'b0;
        check_bit("halt_set", halt, 1'b1);
        tick(4);
        check_bit("halt_held", halt, 1'b1);

        // Halt: clean resume press clears at the debounced edge
        btn_resume = 1'b1;
        tick(PULSE_LAT - 1);
        check_bit("halt_before_resume", halt, 1'b1);
        tick(1);
        check_bit("halt_resumed", halt, 1'b0);
        tick(2);
        btn_resume = 1'b0;
        tick(12);
        check_bit("halt_after_release", halt, 1'b0);

        // Halt: set coincident with resume edge wins
        cpu_halt = 1'b1;
        tick(1);
        cpu_halt = 1'b0;
        tick(2);
        btn_resume = 1'b1;
        tick(PULSE_LAT - 1);
        cpu_halt = 1'b1;
        tick(1);
        cpu_halt = 1'b0;
        check_bit("halt_set_wins", halt, 1'b1);
        tick(3);
        check_bit("halt_set_wins_held", halt, 1'b1);
        btn_resume = 1'b0;
        tick(12);
        check_bit("halt_still_set", halt, 1'b1);

        // Reset mid-REPEAT with the step button held
        pulses_seen = 0;
        k = cyc;
        btn_step = 1'b1;
        push_pulses(k, 3);
        tick(25);
        r = cyc;
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        check_bit("rst_mid_mode", mode, 1'b0);
        check_bit("rst_mid_toggle", manual_toggle, 1'b0);
        check_bit("rst_mid_halt", halt, 1'b0);
        check_int("rst_mid_pulses_before", pulses_seen, 3);
        push_pulses(r + 1, 5);
        tick(29);
        btn_step = 1'b0;
        tick(25);
        check_int("rst_mid_pulse_count", pulses_seen, 8);
        check_int("rst_mid_pending", exp_q.size(), 0);
        check_bit("rst_mid_mode_back", mode, 1'b1);
        check_bit("rst_mid_halt_clear", halt, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
